program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter and data width in bits (legal range 1..32).
REQ-002 Parameter: RESET_VALUE, default 0, value forced onto out by reset, truncated to WIDTH bits.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset; sampled only on rising clk.
REQ-005 Port: data  input  WIDTH  parallel load value.
REQ-006 Port: load  input  1  active-high parallel-load request.
REQ-007 Port: enable  input  1  active-high count-enable.
REQ-008 Port: out  output  WIDTH  current counter value, driven directly from a register.
REQ-009 Port (only when PROGRAM_COUNTER_WRAP_FLAG_EN defined): wrap  output  1  registered wrap-around pulse.

Function
REQ-010 The block SHALL evaluate controls once per rising clk edge, priority reset > load > enable > hold.
REQ-011 reset=1 SHALL set out to RESET_VALUE on that edge, regardless of load, enable or data.
REQ-012 reset=0, load=1 SHALL set out to data on that edge, whether enable is 0 or 1.
REQ-013 reset=0, load=0, enable=1 SHALL set out to out+1 modulo 2^WIDTH on that edge.
REQ-014 reset=0, load=0, enable=0 SHALL hold out unchanged.
REQ-015 Latency: every update SHALL be visible on out one clock edge after the inputs are sampled, with no combinational path from any input to out.
REQ-016 Wrap-around: out = 2^WIDTH-1 with an increment SHALL yield 0 and no error; counting continues.
REQ-017 load with data equal to the current out SHALL leave out unchanged, and no increment occurs in that cycle.
REQ-018 out SHALL be unsigned; no saturation, decrement or step other than +1 exists.
REQ-019 Inputs that change between edges SHALL have no effect until the next rising edge.

Reset
REQ-020 Reset SHALL be synchronous and active-high; asserting it without a clk edge SHALL not change out.
REQ-021 On the first edge with reset=1, out SHALL equal RESET_VALUE, and wrap SHALL equal 0 when present.
REQ-022 Reset asserted mid-count or coincident with load/enable SHALL override them on that edge.
REQ-023 After reset deasserts, the first edge SHALL apply normal priority (load, then enable).
REQ-024 Before the first reset edge, out is undefined; no initial value is required.

Configuration
REQ-025 Macro PROGRAM_COUNTER_WRAP_FLAG_EN, when defined, SHALL add output wrap, which is registered and is 1 for exactly the one cycle following an increment from 2^WIDTH-1 to 0.
REQ-026 wrap SHALL stay 0 after a load (including a load of 0), after a hold, and after reset.
REQ-027 Without PROGRAM_COUNTER_WRAP_FLAG_EN, port wrap and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Reset: reset=1, enable=1, load=1, data=4'hA for one edge -> out=4'h0.
REQ-029 Load without enable: reset=0, enable=0, load=1, data=4'b1010 -> out=4'hA after one edge, and out holds 4'hA once load=0.
REQ-030 Count: load 4'h3, then load=0, enable=1 for 4 edges -> out sequence 4, 5, 6, 7.
REQ-031 Wrap: load 4'hE, enable=1 for 3 edges -> out sequence F, 0, 1; with the macro defined, wrap=1 only in the cycle out=0.
REQ-032 Priority: enable=1, load=1, data=4'h5 while out=4'h9 -> out=4'h5, not 4'hA; then reset=1 with enable=1 -> out=4'h0.
REQ-033 Hold and sync reset: enable=0, load=0 for 5 edges -> out constant; pulse reset between edges only -> out unchanged.

Source files
------------

// File: rtl/program_counter.sv
// Loadable up-counter with synchronous active-high reset; priority is reset > load > enable > hold.
// Define PROGRAM_COUNTER_WRAP_FLAG_EN to add the registered 'wrap' pulse output.
module program_counter #(
  parameter int WIDTH       = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             enable,
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
  output logic             wrap,
`endif
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_Q   = '1;

  logic [WIDTH-1:0] out_q, out_d;

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    out_d = out_q;
    if (load) begin
      out_d = data;
    end else if (enable) begin
      out_d = out_q + ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= RESET_Q;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
  logic wrap_q, wrap_d;

  // Only a real increment past all-ones pulses wrap; loads of zero do not.
  always_comb begin
    wrap_d = !load && enable && (out_q == MAX_Q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Directed testbench for program_counter at default parameters (WIDTH=4, RESET_VALUE=0).
// Wrap checks are compiled in when PROGRAM_COUNTER_WRAP_FLAG_EN is defined.
module tb_program_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data;
  logic       load;
  logic       enable;
  logic [3:0] out;
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
  logic       wrap;
`endif

  int vectors     = 0;
  int miscompares = 0;

  program_counter dut (
    .clk    (clk),
    .reset  (reset),
    .data   (data),
    .load   (load),
    .enable (enable),
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
    .wrap   (wrap),
`endif
    .out    (out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic [3:0] d);
    reset  = r;
    load   = l;
    enable = e;
    data   = d;
  endtask

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_wrap(input string tag, input logic expected);
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
    check(tag, {3'b000, wrap}, {3'b000, expected});
`else
    if (expected === 1'bx) $display("unused %s", tag);
`endif
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    #2;

    // Reset overrides load and enable.
    drive(1'b1, 1'b1, 1'b1, 4'hA);
    tick();
    check("reset_out", out, 4'h0);
    check_wrap("reset_wrap", 1'b0);

    // Load without enable, then hold.
    drive(1'b0, 1'b1, 1'b0, 4'hA);
    tick();
    check("load_a", out, 4'hA);
    drive(1'b0, 1'b0, 1'b0, 4'h3);
    tick();
    check("hold_a1", out, 4'hA);
    tick();
    check("hold_a2", out, 4'hA);

    // Count 4..7 after loading 3.
    drive(1'b0, 1'b1, 1'b0, 4'h3);
    tick();
    check("load_3", out, 4'h3);
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    tick(); check("cnt_4", out, 4'h4);
    tick(); check("cnt_5", out, 4'h5);
    tick(); check("cnt_6", out, 4'h6);
    tick(); check("cnt_7", out, 4'h7);

    // Wrap-around F -> 0 -> 1.
    drive(1'b0, 1'b1, 1'b0, 4'hE);
    tick();
    check("load_e", out, 4'hE);
    check_wrap("load_e_wrap", 1'b0);
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    tick(); check("wrap_f", out, 4'hF); check_wrap("wrap_f_w", 1'b0);
    tick(); check("wrap_0", out, 4'h0); check_wrap("wrap_0_w", 1'b1);
    tick(); check("wrap_1", out, 4'h1); check_wrap("wrap_1_w", 1'b0);

    // Load beats enable; reset beats enable.
    drive(1'b0, 1'b1, 1'b0, 4'h9);
    tick();
    check("load_9", out, 4'h9);
    drive(1'b0, 1'b1, 1'b1, 4'h5);
    tick();
    check("prio_load", out, 4'h5);
    drive(1'b1, 1'b0, 1'b1, 4'h5);
    tick();
    check("prio_reset", out, 4'h0);

    // First edge after reset deasserts follows normal priority.
    drive(1'b0, 1'b1, 1'b1, 4'hC);
    tick();
    check("post_rst_load", out, 4'hC);
    drive(1'b0, 1'b0, 1'b1, 4'hC);
    tick();
    check("post_rst_inc", out, 4'hD);

    // Hold for five edges, with data churning between edges.
    drive(1'b0, 1'b1, 1'b0, 4'h6);
    tick();
    check("load_6", out, 4'h6);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 4'(i + 8));
      tick();
      check("hold_6", out, 4'h6);
      check_wrap("hold_6_wrap", 1'b0);
    end

    // Reset pulsed only between edges has no effect.
    reset = 1'b1;
    #3;
    check("rst_no_edge", out, 4'h6);
    reset = 1'b0;
    tick();
    check("rst_pulse_miss", out, 4'h6);

    // Input changed between edges is not seen until the edge.
    load = 1'b1; data = 4'h2;
    #2;
    check("load_pre_edge", out, 4'h6);
    load = 1'b0;
    tick();
    check("load_dropped", out, 4'h6);

    // Load equal to current value suppresses the increment.
    drive(1'b0, 1'b1, 1'b1, 4'h6);
    tick();
    check("load_same", out, 4'h6);

    // Load of zero after a wrap clears wrap.
    drive(1'b0, 1'b1, 1'b0, 4'hF);
    tick();
    check("load_f", out, 4'hF);
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    tick();
    check("wrap2_0", out, 4'h0);
    check_wrap("wrap2_w", 1'b1);
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    tick();
    check("load_0", out, 4'h0);
    check_wrap("load_0_wrap", 1'b0);

    // Reset coincident with an increment from F.
    drive(1'b0, 1'b1, 1'b0, 4'hF);
    tick();
    drive(1'b1, 1'b0, 1'b1, 4'h0);
    tick();
    check("rst_at_f", out, 4'h0);
    check_wrap("rst_at_f_wrap", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
